// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, op codes and default width for the mul/div sequencer
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage issue/result bundle between the pipeline and the HI/LO sequencer
interface muldiv_seq_if #(parameter int WIDTH = muldiv_pkg::DEF_WIDTH);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mf_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, src_a, src_b, mf_req,
        input  busy, done, stall, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, mf_req,
        output busy, done, stall, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (MULTU) or restoring subtract-shift (DIVU, MULDIV_SEQ_DIVU_EN) iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
`ifdef MULDIV_SEQ_DIVU_EN
    input  logic               i_op,
`endif
    input  logic [2*WIDTH-1:0] i_work,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_work
);

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    assign w_sum      = {1'b0, i_work[2*WIDTH-1:WIDTH]} + (i_work[0] ? {1'b0, i_opnd} : '0);
    assign w_mul_next = {w_sum, i_work[WIDTH-1:1]};

`ifdef MULDIV_SEQ_DIVU_EN
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_fits;
    logic [2*WIDTH-1:0]   w_div_next;

    // Shifted remainder needs one extra bit; when it overflows WIDTH the subtract always fits.
    assign w_rem_sh = i_work[2*WIDTH-1:WIDTH-1];
    assign w_fits   = (w_rem_sh >= {1'b0, i_opnd});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;

    always_comb begin
        w_div_next = {w_rem_sh[WIDTH-1:0], i_work[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            w_div_next = {w_diff, i_work[WIDTH-2:0], 1'b1};
        end
    end

    assign o_work = (i_op == OP_DIVU) ? w_div_next : w_mul_next;
`else
    assign o_work = w_mul_next;
`endif

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned MULTU (and DIVU with MULDIV_SEQ_DIVU_EN) sequencer owning HI/LO
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_work;
    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 w_op_ok;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_busy;
    logic [2*WIDTH-1:0]   w_init_work;
    logic [WIDTH-1:0]     w_init_opnd;

`ifdef MULDIV_SEQ_DIVU_EN
    logic                 r_op;

    assign w_op_ok     = 1'b1;
    assign w_init_work = (bus.op == OP_DIVU) ? {{WIDTH{1'b0}}, bus.src_a} : {{WIDTH{1'b0}}, bus.src_b};
    assign w_init_opnd = (bus.op == OP_DIVU) ? bus.src_b : bus.src_a;
`else
    assign w_op_ok     = (bus.op == OP_MULTU);
    assign w_init_work = {{WIDTH{1'b0}}, bus.src_b};
    assign w_init_opnd = bus.src_a;
`endif

    // A start during RUN is dropped here; the pipeline replays it after the stall.
    assign w_accept = bus.start & w_op_ok & ((r_state == IDLE) | (r_state == DONE));
    assign w_last   = (r_cnt == LAST);
    assign w_busy   = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? RUN : IDLE;
            RUN:        if (w_last) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_SEQ_DIVU_EN
        .i_op   (r_op),
`endif
        .i_work (r_work),
        .i_opnd (r_opnd),
        .o_work (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
`ifdef MULDIV_SEQ_DIVU_EN
            r_op   <= OP_MULTU;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_work <= w_init_work;
            r_opnd <= w_init_opnd;
`ifdef MULDIV_SEQ_DIVU_EN
            r_op   <= bus.op;
`endif
        end else if (w_busy) begin
            r_cnt  <= r_cnt + 1'b1;
            r_work <= w_step;
            // Commit on the final iteration edge so HI/LO are fresh in the DONE cycle.
            if (w_last) begin
                r_hi <= w_step[2*WIDTH-1:WIDTH];
                r_lo <= w_step[WIDTH-1:0];
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = (r_state == DONE);
    assign bus.stall  = w_busy & (bus.start | bus.mf_req);
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_SEQ_DIVU_EN
    localparam bit DIVU_EN = 1'b1;
`else
    localparam bit DIVU_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus_if ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    logic [63:0] exp_q[$];
    int          m_rem  = 0;
    logic        m_done = 1'b0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic [63:0] m_pend = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (o == OP_MULTU) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    // Reference: an accepted op finishes exactly W edges later and then commits its result.
    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
            end else if (bus_if.start && (bus_if.op == OP_MULTU || DIVU_EN)) begin
                m_rem  <= W;
                m_pend <= ref_result(bus_if.op, bus_if.src_a, bus_if.src_b);
                exp_q.push_back(ref_result(bus_if.op, bus_if.src_a, bus_if.src_b));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 64'(bus_if.busy), 64'(m_rem != 0));
            check("done", 64'(bus_if.done), 64'(m_done));
            check("stall", 64'(bus_if.stall), 64'((m_rem != 0) && (bus_if.start || bus_if.mf_req)));
            check("hi_hold", 64'(bus_if.hi_out), 64'(m_hi));
            check("lo_hold", 64'(bus_if.lo_out), 64'(m_lo));
            if (bus_if.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop: got done pulse expected none pending");
                end else begin
                    check("sb_result", {bus_if.hi_out, bus_if.lo_out}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_if.start = 1'b1;
        bus_if.op    = o;
        bus_if.src_a = a;
        bus_if.src_b = b;
        cyc();
        bus_if.start = 1'b0;
        bus_if.src_a = $urandom;
        bus_if.src_b = $urandom;
    endtask

    task automatic wait_done(input string name, output int nb, output int ns);
        nb = 0;
        ns = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_if.done) return;
            if (bus_if.busy) nb++;
            if (bus_if.stall) ns++;
            cyc();
        end
        n_checks++;
        $display("FAIL %s: got no done within 40 cycles expected done", name);
    endtask

    initial begin
        int nb;
        int ns;
        int nd;
        reset         = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.op     = OP_MULTU;
        bus_if.src_a  = '0;
        bus_if.src_b  = '0;
        bus_if.mf_req = 1'b0;
        repeat (3) cyc();
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_done", 64'(bus_if.done), 64'd0);
        check("rst_stall", 64'(bus_if.stall), 64'd0);
        check("rst_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max_mul", nb, ns);
        check("max_busy_cycles", 64'(nb), 64'd32);
        check("max_hi", 64'(bus_if.hi_out), 64'hFFFF_FFFE);
        check("max_lo", 64'(bus_if.lo_out), 64'h0000_0001);
        cyc();

        // Same-cycle start and mf_req in IDLE: no stall, old HI visible.
        bus_if.mf_req = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.op     = OP_MULTU;
        bus_if.src_a  = 32'd7;
        bus_if.src_b  = 32'd6;
        #1;
        check("idle_nostall", 64'(bus_if.stall), 64'd0);
        check("idle_old_hi", 64'(bus_if.hi_out), 64'hFFFF_FFFE);
        bus_if.mf_req = 1'b0;
        cyc();
        bus_if.start  = 1'b0;
        bus_if.mf_req = 1'b1;
        wait_done("mul_7x6", nb, ns);
        check("mf_stall_cycles", 64'(ns), 64'd32);
        check("mf_done_nostall", 64'(bus_if.stall), 64'd0);
        check("mul_7x6_lo", 64'(bus_if.lo_out), 64'd42);
        check("mul_7x6_hi", 64'(bus_if.hi_out), 64'd0);
        bus_if.mf_req = 1'b0;
        cyc();

        issue(OP_MULTU, 32'd9, 32'd11);
        repeat (8) cyc();
        bus_if.start = 1'b1;
        bus_if.src_a = 32'd1;
        bus_if.src_b = 32'd1;
        #1;
        check("busy_start_stall", 64'(bus_if.stall), 64'd1);
        cyc();
        bus_if.start = 1'b0;
        wait_done("mul_9x11", nb, ns);
        check("mul_9x11_lo", 64'(bus_if.lo_out), 64'd99);
        issue(OP_MULTU, 32'd13, 32'd17);
        check("done_reissue_busy", 64'(bus_if.busy), 64'd1);
        wait_done("mul_13x17", nb, ns);
        check("mul_13x17_lo", 64'(bus_if.lo_out), 64'd221);
        cyc();

        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (14) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_busy", 64'(bus_if.busy), 64'd0);
        check("abort_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_if.done) nd++;
            cyc();
        end
        check("abort_no_done", 64'(nd), 64'd0);

        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done("mul_3x5", nb, ns);
        check("mul_3x5_lo", 64'(bus_if.lo_out), 64'd15);
        cyc();
`ifdef MULDIV_SEQ_DIVU_EN
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("div_100_7", nb, ns);
        check("div_100_7_busy", 64'(nb), 64'd32);
        check("div_100_7", {bus_if.hi_out, bus_if.lo_out}, {32'd2, 32'd14});
        cyc();
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done("div_5_0", nb, ns);
        check("div_5_0", {bus_if.hi_out, bus_if.lo_out}, {32'd5, 32'hFFFF_FFFF});
        cyc();
`else
        issue(OP_DIVU, 32'd100, 32'd7);
        check("divu_drop_busy", 64'(bus_if.busy), 64'd0);
        cyc();
        check("divu_drop_hilo", {bus_if.hi_out, bus_if.lo_out}, {32'd0, 32'd15});
`endif

        for (int c = 0; c < 1500; c++) begin
            bus_if.start  = ($urandom_range(0, 5) == 0);
            bus_if.op     = $urandom_range(0, 1);
            bus_if.mf_req = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       bus_if.src_a = '0;
                1:       bus_if.src_a = '1;
                default: bus_if.src_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       bus_if.src_b = '0;
                1:       bus_if.src_b = '1;
                2:       bus_if.src_b = $urandom_range(1, 255);
                default: bus_if.src_b = $urandom;
            endcase
            cyc();
        end
        bus_if.start  = 1'b0;
        bus_if.mf_req = 1'b0;
        repeat (40) cyc();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer for the pipelined CPU's HI/LO resource.
- Accepts a MULTU (and optionally DIVU) issue from EX, iterates one bit per cycle, then commits the 64-bit result into its internal HI/LO register.
- Generates the pipeline stall when a new op or an MFHI/MFLO read arrives while an operation is still in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each and the iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue pulse from EX stage, sampled at rising edge
- op  in  1  0 = MULTU, 1 = DIVU (DIVU only with the macro)
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- mf_req  in  1  MFHI/MFLO in EX wants HI/LO this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, result committed
- stall  out  1  freeze IF/ID/EX this cycle
- hi_out  out  WIDTH  committed HI
- lo_out  out  WIDTH  committed LO

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, iteration counter = 0, working register = 0.
  - hi_out = 0, lo_out = 0, busy = 0, done = 0, stall = 0.
- Reset mid-operation aborts the op; no commit occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1, latch operands, counter = 0, go to RUN.
  - With DIVU disabled, start with op = 1 is ignored (stays IDLE, no busy).
- RUN:
  - One iteration per cycle; counter increments each cycle.
  - After iteration WIDTH-1, go to DONE and write the working register to hi_out/lo_out on that same edge.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - A start in DONE is accepted, exactly as in IDLE.
- Latency:
  - Start sampled at edge E0.
  - busy = 1 for the WIDTH cycles following E0.
  - New hi_out/lo_out are visible after edge E(WIDTH), the same cycle done = 1; 32 cycles for the default width.
- hi_out/lo_out hold their old values throughout RUN.
- MULTU (shift-add):
  - Initialise the 2*WIDTH working register to {0, src_b}.
  - Each iteration: if LSB = 1, add src_a into the upper half with a WIDTH+1-bit carry, then shift the whole register right by 1 (carry enters the MSB).
  - Final result: HI = upper half, LO = lower half.
- stall = busy & (start | mf_req).
  - A start while busy is ignored by the sequencer; the pipeline holds it via stall and re-presents it.
  - mf_req in IDLE or DONE never stalls.
- start and mf_req in the same IDLE cycle: the start is accepted with no stall, and hi_out reflects the previous result during that cycle.
- Operands are latched at start; later src_a/src_b changes have no effect.

Optional Feature:
- Macro: MULDIV_SEQ_DIVU_EN.
- Defined: op = 1 performs an unsigned restoring divide, WIDTH iterations, same latency and handshake as MULTU.
  - Each iteration: shift {rem, quo} left 1, trial-subtract src_b from rem. If no borrow, keep the difference and set quo LSB = 1; otherwise restore.
  - Result: LO = quotient, HI = remainder.
  - Divide by zero is not special-cased: it yields LO = all ones and HI = dividend.
- Undefined: divide hardware is absent; op = 1 starts are dropped as stated in IDLE above.

Decomposition:
- Shared package (muldiv_pkg):
  - State encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Op codes OP_MULTU = 1'b0, OP_DIVU = 1'b1.
  - Default WIDTH.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-shift or subtract-shift selected by op).
- muldiv_seq keeps the FSM, counter, working register and committed HI/LO.

Test Plan:
- Reset, then MULTU src_a = 32'hFFFF_FFFF, src_b = 32'hFFFF_FFFF -> busy 32 cycles; done at cycle 32; hi_out = 32'hFFFF_FFFE, lo_out = 32'h0000_0001.
- MULTU 7 × 6, mf_req held high from cycle 1 -> stall = 1 for cycles 1–32 only; lo_out = 42, hi_out = 0 when done = 1.
- Second start at cycle 10 of a MULTU run -> ignored, stall = 1 that cycle; first result intact; re-issued start accepted in the done cycle.
- reset asserted at cycle 15 of a MULTU 3 × 5 -> next cycle busy = 0, hi_out = lo_out = 0; no done pulse.
- DIVU_EN: DIVU 100 / 7 -> lo_out = 14, hi_out = 2. DIVU 5 / 0 -> lo_out = 32'hFFFF_FFFF, hi_out = 5.
- DIVU_EN undefined: start with op = 1 -> busy stays 0, hi_out/lo_out unchanged.
